// File: rtl/cdc_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing the CDC FIFO write port among N_REQ requesters.
// Define CDC_ARB_SRCID_EN to prepend grant_id to every beat written into the FIFO.
module cdc_wr_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_LEN = 16,
  localparam int unsigned SRC_W  = $clog2(N_REQ),
`ifdef CDC_ARB_SRCID_EN
  localparam int unsigned OUT_W  = DATA_W + SRC_W
`else
  localparam int unsigned OUT_W  = DATA_W
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      wr_valid,
  output logic [OUT_W-1:0]          wr_data,
  output logic                      wr_last,
  input  logic                      wr_ready,
  output logic [SRC_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      len_err
);

  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MAX_LEN - 1);

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  logic             state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             len_err_q, len_err_d;

  logic [SRC_W-1:0] pick;
  logic             pick_vld;
  logic [SRC_W:0]   idx;
  logic [SRC_W-1:0] ptr_inc;
  logic             g_valid, g_last, xfer;
  logic [DATA_W-1:0] g_data;

  // First valid requester at or after rr_ptr, wrapping at N_REQ (not necessarily a power of two).
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr_q} + (SRC_W + 1)'(i);
      if (idx >= (SRC_W + 1)'(N_REQ)) begin
        idx = idx - (SRC_W + 1)'(N_REQ);
      end
      if (!pick_vld && req_valid[idx[SRC_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[SRC_W-1:0];
      end
    end
  end

  assign ptr_inc = (grant_q == SRC_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  assign g_valid = req_valid[grant_q];
  assign g_last  = req_last[grant_q];
  assign g_data  = req_data[grant_q*DATA_W +: DATA_W];

  assign busy     = (state_q == StBusy);
  assign wr_valid = busy & g_valid;
  // Forced last on the MAX_LEN-th beat caps how long one source can hold the port.
  assign wr_last  = busy & (g_last | (beat_cnt_q == LastCnt));
  assign xfer     = wr_valid & wr_ready;
  assign grant_id = grant_q;
  assign len_err  = len_err_q;

`ifdef CDC_ARB_SRCID_EN
  assign wr_data = {grant_q, g_data};
`else
  assign wr_data = g_data;
`endif

  always_comb begin
    req_ready = '0;
    if (busy) begin
      req_ready[grant_q] = wr_ready;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d    = StBusy;
          grant_d    = pick;
          beat_cnt_d = '0;
        end
      end
      StBusy: begin
        if (xfer) begin
          if (wr_last) begin
            state_d    = StIdle;
            beat_cnt_d = '0;
            rr_ptr_d   = ptr_inc;
            len_err_d  = ~g_last;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

endmodule
